gol_cell_driver: RTL and testbench

//  Host-side driver for a single Game-of-Life cell: sits opposite the cell and owns its

---
 rtl/gol_cell_driver_if.sv | 27 ++
 rtl/gol_cell_driver.sv | 191 +++++++++++++++++++
 tb/tb_gol_cell_driver.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gol_cell_driver_if.sv
// Command/response port bundle between a host and gol_cell_driver.
// The host side (master) offers commands and consumes responses; the
// driver side (slave) accepts commands and produces responses.
interface gol_cell_driver_if #(
    parameter int GENS_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_init_alive;
    logic [7:0]        cmd_neighbors;
    logic [GENS_W-1:0] cmd_gens;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_alive;
    logic              rsp_error;
    logic [7:0]        rsp_history;

    modport master (
        output cmd_valid, cmd_init_alive, cmd_neighbors, cmd_gens, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_alive, rsp_error, rsp_history
    );

    modport slave (
        input  cmd_valid, cmd_init_alive, cmd_neighbors, cmd_gens, rsp_ready,
        output cmd_ready, rsp_valid, rsp_alive, rsp_error, rsp_history
    );
endinterface

// File: rtl/gol_cell_driver.sv
// Host-side driver for a single Game-of-Life cell. Forces the cell to a
// commanded initial state, applies a neighbour pattern for a commanded
// number of generations, lets the cell settle under a state-preserving
// pattern, samples alive/notalive and returns the result over a
// valid/ready response port together with the per-generation history.
module gol_cell_driver #(
    parameter int GENS_W = 8,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gol_cell_driver_if.slave     bus,
    output logic [7:0]           cell_neighbors,
    output logic                 cell_set,
    output logic                 cell_reset,
    input  logic                 cell_alive,
    input  logic                 cell_notalive
);

    // Exactly two live neighbours: the cell keeps whatever state it has.
    localparam logic [7:0]        HOLD_PATTERN = 8'b0000_0011;
    localparam int                HOLD_W       = $clog2(SETTLE + 1);
    localparam logic [HOLD_W-1:0] SETTLE_LD    = HOLD_W'(SETTLE);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(1);
    localparam logic [GENS_W-1:0] GENS_ZERO    = {GENS_W{1'b0}};
    localparam logic [GENS_W-1:0] GENS_ONE     = GENS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_STEP = 3'd2,
        S_HOLD = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t              state_r,       state_s;
    logic [GENS_W-1:0]   gens_cnt_r,    gens_cnt_s;
    logic [HOLD_W-1:0]   hold_cnt_r,    hold_cnt_s;
    logic                init_alive_r,  init_alive_s;
    logic [7:0]          pattern_r,     pattern_s;
    logic                step_d_r,      step_d_s;
    logic [7:0]          history_r,     history_s;
    logic                cmd_ready_r,   cmd_ready_s;
    logic                rsp_valid_r,   rsp_valid_s;
    logic                rsp_alive_r,   rsp_alive_s;
    logic                rsp_error_r,   rsp_error_s;
    logic [7:0]          cell_nb_r,     cell_nb_s;
    logic                cell_set_r,    cell_set_s;
    logic                cell_reset_r,  cell_reset_s;

    // Next-state, counters, capture and next values of every registered output
    always_comb begin
        state_s      = state_r;
        gens_cnt_s   = gens_cnt_r;
        hold_cnt_s   = hold_cnt_r;
        init_alive_s = init_alive_r;
        pattern_s    = pattern_r;
        rsp_alive_s  = rsp_alive_r;
        rsp_error_s  = rsp_error_r;
        cell_nb_s    = HOLD_PATTERN;
        cell_set_s   = 1'b0;
        cell_reset_s = 1'b0;

        // The cell registers each generation one clock after the pattern is
        // driven, so history samples the cell one cycle behind STEP: every
        // shifted bit is the cell state produced by a completed generation.
        step_d_s = (state_r == S_STEP);
        if (step_d_r) begin
            history_s = {history_r[6:0], cell_alive};
        end else begin
            history_s = history_r;
        end

        case (state_r)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    init_alive_s = bus.cmd_init_alive;
                    pattern_s    = bus.cmd_neighbors;
                    gens_cnt_s   = bus.cmd_gens;
                    history_s    = 8'h00;
                    state_s      = S_INIT;
                end else begin
                    state_s      = S_IDLE;
                end
            end
            S_INIT: begin
                if (gens_cnt_r != GENS_ZERO) begin
                    state_s    = S_STEP;
                end else begin
                    state_s    = S_HOLD;
                    hold_cnt_s = SETTLE_LD;
                end
            end
            S_STEP: begin
                if (gens_cnt_r == GENS_ONE) begin
                    state_s    = S_HOLD;
                    hold_cnt_s = SETTLE_LD;
                end else begin
                    gens_cnt_s = gens_cnt_r - GENS_ONE;
                end
            end
            S_HOLD: begin
                if (hold_cnt_r <= HOLD_LAST) begin
                    rsp_alive_s = cell_alive;
                    rsp_error_s = (cell_alive == cell_notalive);
                    state_s     = S_RESP;
                end else begin
                    hold_cnt_s  = hold_cnt_r - HOLD_LAST;
                end
            end
            S_RESP: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Cell-facing outputs follow the state being entered so the cell
        // sees them for exactly the cycles the FSM spends in that state.
        case (state_s)
            S_INIT: begin
                cell_set_s   = init_alive_s;
                cell_reset_s = ~init_alive_s;
            end
            S_STEP: begin
                cell_nb_s    = pattern_s;
            end
            S_IDLE, S_HOLD, S_RESP: begin
                cell_nb_s    = HOLD_PATTERN;
            end
            default: begin
                cell_nb_s    = 8'h00;
                cell_reset_s = 1'b1;
            end
        endcase

        cmd_ready_s = (state_s == S_IDLE);
        // Valid rises one cycle after the capture and drops on the handshake.
        rsp_valid_s = (state_r == S_RESP) && (state_s == S_RESP);
    end

    // State register, command latch and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            gens_cnt_r   <= GENS_ZERO;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            init_alive_r <= 1'b0;
            pattern_r    <= 8'h00;
            step_d_r     <= 1'b0;
            history_r    <= 8'h00;
            cmd_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_alive_r  <= 1'b0;
            rsp_error_r  <= 1'b0;
            cell_nb_r    <= 8'h00;
            cell_set_r   <= 1'b0;
            cell_reset_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            gens_cnt_r   <= gens_cnt_s;
            hold_cnt_r   <= hold_cnt_s;
            init_alive_r <= init_alive_s;
            pattern_r    <= pattern_s;
            step_d_r     <= step_d_s;
            history_r    <= history_s;
            cmd_ready_r  <= cmd_ready_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_alive_r  <= rsp_alive_s;
            rsp_error_r  <= rsp_error_s;
            cell_nb_r    <= cell_nb_s;
            cell_set_r   <= cell_set_s;
            cell_reset_r <= cell_reset_s;
        end
    end

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_alive   = rsp_alive_r;
    assign bus.rsp_error   = rsp_error_r;
    assign bus.rsp_history = history_r;
    assign cell_neighbors  = cell_nb_r;
    assign cell_set        = cell_set_r;
    assign cell_reset      = cell_reset_r;

endmodule

// File: tb/tb_gol_cell_driver.sv
// Bench for gol_cell_driver: behavioural Game-of-Life cell on the same
// clock, a directed vector table, hand-written corner sequences and
// randomized commands checked against a generation-level reference model.
module tb_gol_cell_driver;

    localparam int SETTLE = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] cell_neighbors;
    logic       cell_set;
    logic       cell_reset;
    logic       cell_alive;
    logic       cell_notalive;
    logic       cell_q;
    bit         force_err;

    int total = 0;
    int bad   = 0;

    gol_cell_driver_if #(.GENS_W(8)) bus ();

    gol_cell_driver #(.GENS_W(8), .SETTLE(SETTLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .cell_neighbors (cell_neighbors),
        .cell_set       (cell_set),
        .cell_reset     (cell_reset),
        .cell_alive     (cell_alive),
        .cell_notalive  (cell_notalive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game-of-Life rule on a neighbour count
    function automatic bit life(input int n, input bit cur);
        return (n == 3) || (n == 2 && cur);
    endfunction

    // Behavioural cell: synchronous set/reset, otherwise one generation per clock
    always @(posedge clk) begin
        if (cell_reset) cell_q <= 1'b0;
        else if (cell_set) cell_q <= 1'b1;
        else cell_q <= life($countones(cell_neighbors), cell_q);
    end
    assign cell_alive    = cell_q;
    assign cell_notalive = force_err ? cell_q : ~cell_q;

    // Reference: outcome of a command evaluated generation by generation
    function automatic void ref_model(input bit init, input logic [7:0] nb, input int gens,
                                      output bit alive, output logic [7:0] hist);
        int n = $countones(nb);
        alive = init;
        hist  = 8'h00;
        for (int g = 0; g < gens; g++) begin
            alive = life(n, alive);
            hist  = {hist[6:0], alive};
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One complete command/response transaction with latency and stability checks
    task automatic run_cmd(input bit init, input logic [7:0] nb, input logic [7:0] gens,
                           input bit exp_alive, input bit exp_err, input logic [7:0] exp_hist,
                           input int ready_delay, input bit early, input string tag);
        int guard = 0;
        int lat   = 0;
        bit seen  = 1'b0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, " ready_wait"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid      = 1'b1;
        bus.cmd_init_alive = init;
        bus.cmd_neighbors  = nb;
        bus.cmd_gens       = gens;
        @(posedge clk); #1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_neighbors  = ~nb;
        bus.cmd_init_alive = ~init;
        bus.cmd_gens       = 8'hA5;
        check({tag, " ready_drop"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, " set"},        32'(cell_set),      32'(init));
        check({tag, " reset"},      32'(cell_reset),    32'(!init));
        if (early) bus.rsp_ready = 1'b1;
        while (lat < 400) begin
            @(posedge clk); #1; lat++;
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " valid_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"},    32'(lat),  32'(int'(gens) + SETTLE + 2));
        check({tag, " alive"},      32'(bus.rsp_alive),   32'(exp_alive));
        check({tag, " error"},      32'(bus.rsp_error),   32'(exp_err));
        check({tag, " history"},    32'(bus.rsp_history), 32'(exp_hist));
        if (!early) begin
            for (int d = 0; d < ready_delay; d++) begin
                @(posedge clk); #1;
                check({tag, " hold_valid"}, 32'(bus.rsp_valid),   32'd1);
                check({tag, " hold_alive"}, 32'(bus.rsp_alive),   32'(exp_alive));
                check({tag, " hold_hist"},  32'(bus.rsp_history), 32'(exp_hist));
                check({tag, " hold_crdy"},  32'(bus.cmd_ready),   32'd0);
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, " valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " ready_back"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    typedef struct {
        bit         init;
        logic [7:0] nb;
        logic [7:0] gens;
        bit         exp_alive;
        logic [7:0] exp_hist;
        int         ready_delay;
        bit         early;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         rinit;
        bit         ealive;
        logic [7:0] rnb;
        logic [7:0] rgens;
        logic [7:0] ehist;
        int         cnt;

        //          init  nb     gens   alive hist   delay early
        vecs[0] = '{1'b1, 8'h07, 8'd1,   1'b1, 8'h01, 0, 1'b0};
        vecs[1] = '{1'b0, 8'h0E, 8'd4,   1'b1, 8'h0F, 6, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 8'd3,   1'b0, 8'h00, 1, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 8'd0,   1'b1, 8'h00, 0, 1'b1};
        vecs[4] = '{1'b0, 8'h03, 8'd2,   1'b0, 8'h00, 2, 1'b0};
        vecs[5] = '{1'b1, 8'h81, 8'd3,   1'b1, 8'h07, 0, 1'b0};
        vecs[6] = '{1'b1, 8'h0F, 8'd2,   1'b0, 8'h00, 1, 1'b1};
        vecs[7] = '{1'b0, 8'hE0, 8'd10,  1'b1, 8'hFF, 0, 1'b0};
        vecs[8] = '{1'b0, 8'hFF, 8'd1,   1'b0, 8'h00, 3, 1'b0};
        vecs[9] = '{1'b1, 8'h07, 8'd255, 1'b1, 8'hFF, 0, 1'b0};

        rst_n              = 1'b0;
        force_err          = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_init_alive = 1'b0;
        bus.cmd_neighbors  = 8'h00;
        bus.cmd_gens       = 8'h00;
        bus.rsp_ready      = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst cmd_ready",   32'(bus.cmd_ready),   32'd0);
        check("rst cell_nb",     32'(cell_neighbors),  32'h00);
        check("rst cell_set",    32'(cell_set),        32'd0);
        check("rst cell_reset",  32'(cell_reset),      32'd1);
        check("rst rsp_valid",   32'(bus.rsp_valid),   32'd0);
        check("rst rsp_alive",   32'(bus.rsp_alive),   32'd0);
        check("rst rsp_error",   32'(bus.rsp_error),   32'd0);
        check("rst rsp_history", 32'(bus.rsp_history), 32'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel cmd_ready",  32'(bus.cmd_ready), 32'd1);
        check("rel cell_reset", 32'(cell_reset),    32'd0);
        check("rel cell_nb",    32'(cell_neighbors), 32'h03);
        check("rel cell_dead",  32'(cell_alive),    32'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].init, vecs[i].nb, vecs[i].gens, vecs[i].exp_alive, 1'b0,
                    vecs[i].exp_hist, vecs[i].ready_delay, vecs[i].early,
                    $sformatf("vec%0d", i));
        end

        // Cell reporting an inconsistent alive/notalive pair
        force_err = 1'b1;
        run_cmd(1'b1, 8'h07, 8'd2, 1'b1, 1'b1, 8'h03, 0, 1'b0, "err");
        force_err = 1'b0;
        run_cmd(1'b0, 8'h07, 8'd1, 1'b1, 1'b0, 8'h01, 0, 1'b0, "err_clear");

        // Reset in the middle of a long STEP phase
        bus.cmd_valid      = 1'b1;
        bus.cmd_init_alive = 1'b1;
        bus.cmd_neighbors  = 8'h07;
        bus.cmd_gens       = 8'd200;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid step_nb", 32'(cell_neighbors), 32'h07);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid cell_reset", 32'(cell_reset),      32'd1);
        check("mid rsp_valid",  32'(bus.rsp_valid),   32'd0);
        check("mid cmd_ready",  32'(bus.cmd_ready),   32'd0);
        check("mid history",    32'(bus.rsp_history), 32'h00);
        check("mid cell_nb",    32'(cell_neighbors),  32'h00);
        cnt = 0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 260; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) cnt++;
        end
        bus.rsp_ready = 1'b0;
        check("mid no_rsp",    32'(cnt),        32'd0);
        check("mid cell_dead", 32'(cell_alive), 32'd0);
        run_cmd(1'b0, 8'h0E, 8'd4, 1'b1, 1'b0, 8'h0F, 1, 1'b0, "post_rst");

        // Randomized commands against the reference model
        for (int r = 0; r < 25; r++) begin
            rinit = 1'($urandom_range(0, 1));
            rnb   = 8'($urandom);
            rgens = 8'($urandom_range(0, 24));
            ref_model(rinit, rnb, int'(rgens), ealive, ehist);
            run_cmd(rinit, rnb, rgens, ealive, 1'b0, ehist, int'($urandom_range(0, 3)),
                    (r % 4) == 0, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
